// File: rtl/axi_read_router.sv
// AXI read-side router: registers one master AR, forwards it to the decoded
// slave, and returns R beats in issue order through a FIFO of slave indices.
module axi_read_router #(
    parameter int IDW      = 4,
    parameter int DW       = 32,
    parameter int OT_DEPTH = 4
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic              ARVALID_M,
    output logic              ARREADY_M,
    input  logic [31:0]       ARADDR_M,
    input  logic [IDW-1:0]    ARID_M,
    input  logic [3:0]        ARLEN_M,
    output logic              dec_valid,
    output logic [31:0]       dec_addr,
    input  logic [5:0]        dec_sel,
    output logic [5:0]        ARVALID_S,
    input  logic [5:0]        ARREADY_S,
    output logic [31:0]       ARADDR_S,
    output logic [IDW-1:0]    ARID_S,
    output logic [3:0]        ARLEN_S,
    input  logic [5:0]        RVALID_S,
    output logic [5:0]        RREADY_S,
    input  logic [6*DW-1:0]   RDATA_S,
    input  logic [6*IDW-1:0]  RID_S,
    input  logic [11:0]       RRESP_S,
    input  logic [5:0]        RLAST_S,
    output logic              RVALID_M,
    input  logic              RREADY_M,
    output logic [DW-1:0]     RDATA_M,
    output logic [IDW-1:0]    RID_M,
    output logic [1:0]        RRESP_M,
    output logic              RLAST_M
);

    localparam int PW = $clog2(OT_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {
        IDLE,
        ISSUE
    } state_e;

    state_e         state_q, state_d;
    logic [31:0]    addr_q, addr_d;
    logic [IDW-1:0] id_q, id_d;
    logic [3:0]     len_q, len_d;
    logic [2:0]     fifo_q [OT_DEPTH];
    logic [2:0]     fifo_d [OT_DEPTH];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;

    logic [2:0] tgt;
    logic [2:0] head;
    logic       ar_ok;
    logic       push;
    logic       pop;
    logic       empty;

    // Anything other than a clean one-hot select goes to the default slave.
    always_comb begin
        tgt = 3'd5;
        case (dec_sel)
            6'b000001: tgt = 3'd0;
            6'b000010: tgt = 3'd1;
            6'b000100: tgt = 3'd2;
            6'b001000: tgt = 3'd3;
            6'b010000: tgt = 3'd4;
            default:   tgt = 3'd5;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        id_d      = id_q;
        len_d     = len_q;
        ARREADY_M = 1'b0;
        dec_valid = 1'b0;
        ARVALID_S = '0;
        push      = 1'b0;
        ar_ok     = count_q < CW'(OT_DEPTH);
        unique case (state_q)
            IDLE: begin
                ARREADY_M = ar_ok;
                if (ARVALID_M && ar_ok) begin
                    addr_d  = ARADDR_M;
                    id_d    = ARID_M;
                    len_d   = ARLEN_M;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                dec_valid      = 1'b1;
                ARVALID_S[tgt] = 1'b1;
                if (ARREADY_S[tgt]) begin
                    push    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign dec_addr = addr_q;
    assign ARADDR_S = addr_q;
    assign ARID_S   = id_q;
    assign ARLEN_S  = len_q;

    assign head  = fifo_q[rd_ptr_q];
    assign empty = (count_q == '0);

    always_comb begin
        RVALID_M = 1'b0;
        RREADY_S = '0;
        RDATA_M  = '0;
        RID_M    = '0;
        RRESP_M  = '0;
        RLAST_M  = 1'b0;
        if (!empty) begin
            RVALID_M       = RVALID_S[head];
            RREADY_S[head] = RREADY_M;
            RDATA_M        = RDATA_S[head*DW +: DW];
            RID_M          = RID_S[head*IDW +: IDW];
            RRESP_M        = RRESP_S[head*2 +: 2];
            RLAST_M        = RLAST_S[head];
        end
    end

    assign pop = RVALID_M && RREADY_M && RLAST_M;

    always_comb begin
        fifo_d = fifo_q;
        if (push) begin
            fifo_d[wr_ptr_q] = tgt;
        end
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            id_q     <= '0;
            len_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < OT_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            id_q     <= id_d;
            len_q    <= len_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            fifo_q   <= fifo_d;
        end
    end

endmodule

// File: tb/tb_axi_read_router.sv
// Randomised bench for axi_read_router against a queue-based model of
// outstanding reads, plus directed fill, stall, ordering and reset cases.
module tb_axi_read_router;

    localparam int IDW = 4;
    localparam int DW  = 32;
    localparam int OT  = 4;

    logic              ACLK;
    logic              ARESET;
    logic              ARVALID_M;
    logic              ARREADY_M;
    logic [31:0]       ARADDR_M;
    logic [IDW-1:0]    ARID_M;
    logic [3:0]        ARLEN_M;
    logic              dec_valid;
    logic [31:0]       dec_addr;
    logic [5:0]        dec_sel;
    logic [5:0]        ARVALID_S;
    logic [5:0]        ARREADY_S;
    logic [31:0]       ARADDR_S;
    logic [IDW-1:0]    ARID_S;
    logic [3:0]        ARLEN_S;
    logic [5:0]        RVALID_S;
    logic [5:0]        RREADY_S;
    logic [6*DW-1:0]   RDATA_S;
    logic [6*IDW-1:0]  RID_S;
    logic [11:0]       RRESP_S;
    logic [5:0]        RLAST_S;
    logic              RVALID_M;
    logic              RREADY_M;
    logic [DW-1:0]     RDATA_M;
    logic [IDW-1:0]    RID_M;
    logic [1:0]        RRESP_M;
    logic              RLAST_M;

    axi_read_router #(.IDW(IDW), .DW(DW), .OT_DEPTH(OT)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .ARVALID_M(ARVALID_M), .ARREADY_M(ARREADY_M),
        .ARADDR_M(ARADDR_M), .ARID_M(ARID_M), .ARLEN_M(ARLEN_M),
        .dec_valid(dec_valid), .dec_addr(dec_addr), .dec_sel(dec_sel),
        .ARVALID_S(ARVALID_S), .ARREADY_S(ARREADY_S),
        .ARADDR_S(ARADDR_S), .ARID_S(ARID_S), .ARLEN_S(ARLEN_S),
        .RVALID_S(RVALID_S), .RREADY_S(RREADY_S), .RDATA_S(RDATA_S),
        .RID_S(RID_S), .RRESP_S(RRESP_S), .RLAST_S(RLAST_S),
        .RVALID_M(RVALID_M), .RREADY_M(RREADY_M), .RDATA_M(RDATA_M),
        .RID_M(RID_M), .RRESP_M(RRESP_M), .RLAST_M(RLAST_M)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    int n_cmp = 0;
    int n_err = 0;

    // Reference: pending AR plus in-order list of target slaves.
    int             q[$];
    bit             m_pend;
    logic [31:0]    m_addr;
    logic [IDW-1:0] m_id;
    logic [3:0]     m_len;

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int tgt_of(logic [5:0] s);
        if ($countones(s) != 1) return 5;
        for (int i = 0; i < 6; i++) if (s[i]) return i;
        return 5;
    endfunction

    task automatic model_reset();
        q.delete();
        m_pend = 0;
        m_addr = '0;
        m_id   = '0;
        m_len  = '0;
    endtask

    task automatic compare_all();
        logic [5:0]     one;
        logic [5:0]     e_arv;
        logic [5:0]     e_rrdy;
        logic           e_rv;
        logic [DW-1:0]  e_data;
        logic [IDW-1:0] e_id;
        logic [1:0]     e_resp;
        logic           e_last;
        int h;
        one    = 6'b000001;
        e_arv  = m_pend ? (one << tgt_of(dec_sel)) : 6'b0;
        e_rrdy = '0;
        e_rv   = 0;
        e_data = '0;
        e_id   = '0;
        e_resp = '0;
        e_last = 0;
        if (q.size() > 0) begin
            h      = q[0];
            e_rv   = RVALID_S[h];
            e_rrdy = 6'(RREADY_M) << h;
            e_data = RDATA_S[h*DW +: DW];
            e_id   = RID_S[h*IDW +: IDW];
            e_resp = RRESP_S[h*2 +: 2];
            e_last = RLAST_S[h];
        end
        check("arready_m", 64'(ARREADY_M), 64'(!m_pend && q.size() < OT));
        check("dec_valid", 64'(dec_valid), 64'(m_pend));
        check("dec_addr", 64'(dec_addr), 64'(m_addr));
        check("araddr_s", 64'(ARADDR_S), 64'(m_addr));
        check("arid_s", 64'(ARID_S), 64'(m_id));
        check("arlen_s", 64'(ARLEN_S), 64'(m_len));
        check("arvalid_s", 64'(ARVALID_S), 64'(e_arv));
        check("rvalid_m", 64'(RVALID_M), 64'(e_rv));
        check("rready_s", 64'(RREADY_S), 64'(e_rrdy));
        check("rdata_m", 64'(RDATA_M), 64'(e_data));
        check("rid_m", 64'(RID_M), 64'(e_id));
        check("rresp_m", 64'(RRESP_M), 64'(e_resp));
        check("rlast_m", 64'(RLAST_M), 64'(e_last));
    endtask

    task automatic model_update();
        int  t;
        int  h;
        bit  do_pop;
        if (ARESET) return;
        t      = tgt_of(dec_sel);
        do_pop = 0;
        if (q.size() > 0) begin
            h = q[0];
            do_pop = RVALID_S[h] && RREADY_M && RLAST_S[h];
        end
        if (m_pend) begin
            if (ARREADY_S[t]) begin
                q.push_back(t);
                m_pend = 0;
            end
        end else if (ARVALID_M && q.size() < OT) begin
            m_pend = 1;
            m_addr = ARADDR_M;
            m_id   = ARID_M;
            m_len  = ARLEN_M;
        end
        if (do_pop) void'(q.pop_front());
    endtask

    task automatic rand_data();
        for (int k = 0; k < 6; k++) RDATA_S[k*DW +: DW] = $urandom;
        RID_S   = 24'($urandom);
        RRESP_S = 12'($urandom);
    endtask

    // Called at posedge+1: inputs are held until the next posedge+1.
    task automatic step();
        rand_data();
        @(negedge ACLK);
        compare_all();
        @(posedge ACLK);
        model_update();
        #1;
    endtask

    task automatic clear_inputs();
        ARVALID_M = 0;
        ARADDR_M  = '0;
        ARID_M    = '0;
        ARLEN_M   = '0;
        dec_sel   = '0;
        ARREADY_S = '0;
        RVALID_S  = '0;
        RLAST_S   = '0;
        RREADY_M  = 0;
    endtask

    task automatic rand_inputs();
        int r;
        ARVALID_M = 1'($urandom);
        ARADDR_M  = $urandom;
        ARID_M    = IDW'($urandom);
        ARLEN_M   = 4'($urandom);
        r = $urandom_range(0, 9);
        if (r < 8) dec_sel = 6'b000001 << $urandom_range(0, 5);
        else if (r == 8) dec_sel = '0;
        else dec_sel = 6'($urandom);
        ARREADY_S = 6'($urandom);
        RVALID_S  = 6'($urandom);
        RLAST_S   = 6'($urandom) & 6'($urandom);
        RREADY_M  = 1'($urandom);
    endtask

    task automatic issue(logic [5:0] sel, logic [31:0] addr);
        ARVALID_M = 1;
        ARADDR_M  = addr;
        ARID_M    = IDW'($urandom);
        ARLEN_M   = 4'($urandom);
        dec_sel   = sel;
        ARREADY_S = sel;
        step();
        ARVALID_M = 0;
        step();
    endtask

    task automatic pulse_reset();
        ARESET = 1;
        model_reset();
        #2;
        check("rst_arvalid_s", 64'(ARVALID_S), 64'd0);
        check("rst_rvalid_m", 64'(RVALID_M), 64'd0);
        check("rst_rready_s", 64'(RREADY_S), 64'd0);
        check("rst_dec_valid", 64'(dec_valid), 64'd0);
        step();
        ARESET = 0;
    endtask

    initial begin
        clear_inputs();
        rand_data();
        model_reset();
        ARESET = 1;
        #1;
        step();
        step();
        ARESET = 0;
        step();

        // single read to slave 1, four beats
        issue(6'b000010, 32'h0001_0004);
        RREADY_M = 1;
        for (int b = 0; b < 4; b++) begin
            RVALID_S = 6'b000010;
            RLAST_S  = (b == 3) ? 6'b000010 : 6'b0;
            step();
        end
        clear_inputs();
        step();

        // fill all outstanding slots, then free one
        ARVALID_M = 1;
        dec_sel   = 6'b000001;
        ARREADY_S = 6'h3f;
        repeat (12) step();
        ARVALID_M = 0;
        RVALID_S  = 6'h3f;
        RLAST_S   = 6'h3f;
        RREADY_M  = 1;
        step();
        RVALID_S = 0;
        step();
        RVALID_S = 6'h3f;
        repeat (4) step();
        clear_inputs();

        // stalled issue to the default slave
        ARVALID_M = 1;
        ARADDR_M  = 32'h3000_0000;
        dec_sel   = 6'b100000;
        step();
        ARVALID_M = 0;
        repeat (10) step();
        ARREADY_S = 6'b100000;
        step();
        clear_inputs();

        // drain the read above, then ordering across slaves
        RVALID_S = 6'b100000;
        RLAST_S  = 6'b100000;
        RREADY_M = 1;
        step();
        clear_inputs();
        issue(6'b000001, 32'h0000_0100);
        issue(6'b001000, 32'h0003_0000);
        issue(6'b000001, 32'h0000_0200);
        RREADY_M = 1;
        RVALID_S = 6'b001000;
        RLAST_S  = 6'b001000;
        repeat (3) step();
        RVALID_S = 6'b001001;
        RLAST_S  = 6'b001001;
        repeat (3) step();
        clear_inputs();

        // reset with outstanding reads and a burst in flight
        issue(6'b000100, 32'h0002_0000);
        issue(6'b010000, 32'h0004_0000);
        RVALID_S = 6'b000100;
        RREADY_M = 1;
        step();
        pulse_reset();
        RVALID_S = 6'h3f;
        RLAST_S  = 6'h3f;
        repeat (3) step();
        clear_inputs();

        for (int c = 0; c < 1500; c++) begin
            rand_inputs();
            if ($urandom_range(0, 199) == 0) pulse_reset();
            else step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
